// File: rtl/sweep_pkg.sv
// Shared types and helpers for the logic sweep checker.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Upper bound on the DUT input count the compare helper can handle.
    localparam int N_IN_MAX = 8;
    localparam int TT_W_MAX = 1 << N_IN_MAX;

    function automatic int first_mismatch(
        input logic [TT_W_MAX-1:0] tt_act,
        input logic [TT_W_MAX-1:0] tt_exp,
        input int                  width
    );
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < TT_W_MAX; i++) begin
            if (!found && (i < width) && (tt_act[i] != tt_exp[i])) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/logic_sweep_checker_timer.sv
// Loadable down-counter with zero flag; paces the settle wait of each vector.
module sweep_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustive truth-table sweep of a small combinational block, compared
// against an expected table.
//
//   state  | meaning
//   IDLE   | waiting for start; stim held at 0
//   DRIVE  | current vector on stim, settle counter running
//   SAMPLE | capture resp into tt[stim]; advance or finish
//   DONE   | one-cycle done pulse; pass/fail_idx valid
module logic_sweep_checker
    import sweep_pkg::*;
#(
    parameter int                    N_IN   = 3,
    parameter int                    SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = 8'hF8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        stim,
    input  logic                   resp,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic                   pass,
    output logic [N_IN-1:0]        fail_idx
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  STIM_LAST   = N_IN'(TT_W - 1);
    localparam logic [N_IN-1:0]  STIM_ONE    = N_IN'(1);

    state_t            state, state_next;
    logic [N_IN-1:0]   stim_next;
    logic [TT_W-1:0]   tt_next;
    logic              busy_next;
    logic              pass_next;
    logic [N_IN-1:0]   fail_next;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    sweep_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_next = state;
        stim_next  = stim;
        tt_next    = tt;
        busy_next  = busy;
        pass_next  = pass;
        fail_next  = fail_idx;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                stim_next = '0;
                if (state == DONE) begin
                    state_next = IDLE;
                end
                // A start still high in DONE chains straight into the next sweep.
                if (start) begin
                    tt_next    = '0;
                    pass_next  = 1'b0;
                    fail_next  = '0;
                    busy_next  = 1'b1;
                    tmr_load   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (tmr_zero) begin
                    state_next = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAMPLE: begin
                tt_next[stim] = resp;
                if (stim == STIM_LAST) begin
                    stim_next  = '0;
                    busy_next  = 1'b0;
                    pass_next  = (tt_next == EXPECT);
                    fail_next  = N_IN'(first_mismatch(TT_W_MAX'(tt_next),
                                                      TT_W_MAX'(EXPECT), TT_W));
                    state_next = DONE;
                end else begin
                    stim_next  = stim + STIM_ONE;
                    tmr_load   = 1'b1;
                    state_next = DRIVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            stim     <= '0;
            tt       <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= '0;
        end else begin
            state    <= state_next;
            stim     <= stim_next;
            tt       <= tt_next;
            busy     <= busy_next;
            pass     <= pass_next;
            fail_idx <= fail_next;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Scoreboard bench for logic_sweep_checker driving a z = x1 | (x2 & x3) model.
module tb_logic_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] stim;
    logic       resp;
    logic       busy;
    logic       done;
    logic [7:0] tt;
    logic       pass;
    logic [2:0] fail_idx;

    logic       z;
    int         resp_mode;
    int         cyc;
    int         sweep_t;
    int         checks;
    int         failures;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [2:0] fidx;
        int         done_at;
    } exp_t;

    exp_t exp_q[$];

    logic_sweep_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stim     (stim),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .pass     (pass),
        .fail_idx (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        z = stim[2] | (stim[1] & stim[0]);
        case (resp_mode)
            1:       resp = 1'b0;
            2:       resp = ~z;
            default: resp = z;
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: per-cycle stim/busy against the sweep timeline, results on done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("stim", stim,
                  (cyc >= sweep_t && cyc < sweep_t + 24) ? (cyc - sweep_t) / 3 : 0);
            if (sweep_t >= 0) begin
                if (cyc >= sweep_t && cyc < sweep_t + 24)
                    check("busy_active", busy, 1);
                else if (cyc >= sweep_t + 26)
                    check("busy_idle", busy, 0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_at);
                    check("tt", tt, e.tt);
                    check("pass", pass, e.pass);
                    check("fail_idx", fail_idx, e.fidx);
                end
            end
        end
    end

    task automatic start_sweep(input logic [7:0] ett, input logic ep,
                               input logic [2:0] efi, output int t);
        exp_t e;
        @(negedge clk);
        t        = cyc + 1;
        start    = 1'b1;
        sweep_t  = t;
        e.tt     = ett;
        e.pass   = ep;
        e.fidx   = efi;
        e.done_at = t + 24;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout at cycle %0d: got %0d pending, expected 0", cyc, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cycle(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int t;
        exp_t e;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        resp_mode = 0;
        sweep_t   = -1000;

        #3;
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tt", tt, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_idx", fail_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal DUT, zero response, inverted response
        resp_mode = 0;
        start_sweep(8'hF8, 1'b1, 3'd0, t);
        wait_idle(60);
        resp_mode = 1;
        start_sweep(8'h00, 1'b0, 3'd3, t);
        wait_idle(60);
        resp_mode = 2;
        start_sweep(8'h07, 1'b0, 3'd0, t);
        wait_idle(60);

        // start re-pulsed while busy must be ignored
        resp_mode = 0;
        start_sweep(8'hF8, 1'b1, 3'd0, t);
        wait_cycle(t + 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycle(t + 11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);

        // Reset mid-sweep while vector 4 is driven
        start_sweep(8'hF8, 1'b1, 3'd0, t);
        wait_cycle(t + 12);
        @(posedge clk);
        #1;
        check("stim_before_rst", stim, 4);
        exp_q.delete();
        sweep_t = -1000;
        rst_n   = 1'b0;
        #1;
        check("midrst_stim", stim, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tt", tt, 0);
        check("midrst_done", done, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_sweep(8'hF8, 1'b1, 3'd0, t);
        wait_idle(60);

        // start held high: back-to-back sweeps every 25 cycles
        @(negedge clk);
        t       = cyc + 1;
        start   = 1'b1;
        sweep_t = t;
        for (int k = 0; k < 3; k++) begin
            e.tt      = 8'hF8;
            e.pass    = 1'b1;
            e.fidx    = 3'd0;
            e.done_at = t + 24 + 25 * k;
            exp_q.push_back(e);
        end
        wait_cycle(t + 24);
        sweep_t = t + 25;
        @(negedge clk);
        check("restart_tt_clear", tt, 0);
        wait_cycle(t + 49);
        sweep_t = t + 50;
        @(negedge clk);
        check("restart2_tt_clear", tt, 0);
        start = 1'b0;
        wait_idle(100);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
